mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
Sequencer for the MEM stage of the 5-stage RISC-V pipeline. It consumes the control and data outputs of the EX/MEM pipeline register. It runs a req/ack handshake to a variable-latency data memory and stalls the pipeline, holding EX/MEM and all earlier registers, until each access completes. It also resolves the branch decision (branch & zero) into pc_src and a flush for the IF/ID and ID/EX registers.

Parameters:
ADDR_W, 32, data memory address width (taken from alu_result[ADDR_W-1:0])
DATA_W, 32, data word width
TIMEOUT, 255, max REQ cycles before abort (used only with MEM_TIMEOUT_EN)
CNT_W, 16, width of the stall-cycle counter

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
branch  in  1  EX/MEM branch control
zero  in  1  EX/MEM ALU zero flag
memread  in  1  EX/MEM load request
memwrite  in  1  EX/MEM store request
alu_result  in  32  EX/MEM effective address
rdata2out  in  DATA_W  EX/MEM store data
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = write, 0 = read; valid with dmem_req
dmem_addr  out  ADDR_W  registered address
dmem_wdata  out  DATA_W  registered store data
dmem_ack  in  1  memory completion pulse
dmem_rdata  in  DATA_W  read data, valid with dmem_ack
stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
pc_src  out  1  take branch target
flush  out  1  clear IF/ID and ID/EX
load_data  out  DATA_W  captured read data, to MEM/WB
load_valid  out  1  one-cycle pulse: load_data updated
mem_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- FSM states: IDLE, REQ, DONE.
- IDLE: if memread|memwrite, then at the next edge go to REQ. On that edge, set dmem_req=1, dmem_we=memwrite, and latch addr and wdata. memread & memwrite both high is treated as a write.
- REQ: dmem_req held at 1 and addr/wdata stable until dmem_ack. On the ack edge: dmem_req=0; if read, load_data<=dmem_rdata and load_valid=1 for one cycle; go to DONE. Minimum latency is ack in the first REQ cycle, so an access costs 2 stall cycles.
- DONE: stall=0 so EX/MEM advances at this edge; unconditionally return to IDLE. This guarantees the same instruction is never issued twice.
- stall (combinational) = (IDLE & (memread|memwrite)) | REQ.
- dmem_ack outside REQ is ignored.
- pc_src = branch & zero (combinational). flush = pc_src & ~stall.
- stall_cnt increments by 1 on each edge where stall=1 and saturates at all-ones.
- Reset values (reset=0, asynchronous):
  - state=IDLE
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0
  - load_data=0, load_valid=0
  - mem_err=0, stall_cnt=0
- Reset mid-REQ drops dmem_req immediately. A late ack after reset is ignored.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a counter of width clog2(TIMEOUT+1) clears on entry to REQ and increments each REQ cycle. When it reaches TIMEOUT with no ack, the access is aborted: dmem_req=0, mem_err<=1 (sticky until reset), go to DONE. For a read, load_data<=0 and load_valid pulses. An ack arriving on the same edge as the timeout wins, and mem_err stays unchanged.
- Undefined: no counter; mem_err tied to 0; REQ waits indefinitely.

Decomposition:
- Shared package rv_pipe_pkg:
  - state enum mem_state_t {IDLE, REQ, DONE}
  - XLEN=32 constant
  - memory op encoding constants
- One natural sub-module: sat_counter (CNT_W-parameterised saturating counter) for stall_cnt. It is reused by the timeout counter when MEM_TIMEOUT_EN is defined.

Test Plan:
- Load, ack 1 cycle after req: memread=1, alu_result=0x100, dmem_rdata=0xDEADBEEF -> dmem_req high 1 cycle with addr=0x100 and we=0; load_data=0xDEADBEEF; load_valid pulse; stall high 2 cycles; stall_cnt=2.
- Store, ack delayed 5 cycles: memwrite=1, rdata2out=0x12345678 -> dmem_we=1 and wdata stable for all 5 REQ cycles; stall high 6 cycles; single request only.
- Branch: branch=1, zero=1, no memory op -> pc_src=1, flush=1 the same cycle. With zero=0 -> both 0.
- Reset mid-REQ: reset=0 on REQ cycle 2, then ack on the next cycle -> dmem_req=0 immediately, state IDLE, load_valid never pulses, all outputs 0.
- Spurious ack in IDLE with no memory op -> no load_valid, load_data unchanged, stall=0.
- With MEM_TIMEOUT_EN and TIMEOUT=4, never ack -> dmem_req drops after 4 REQ cycles; mem_err=1 and sticky; load_data=0; pipeline resumes.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline MEM stage: access FSM states,
// the datapath width and the memory-operation encoding seen on dmem_we.
package rv_pipe_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_stage_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; once the count reaches all-ones it holds there.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count register: clear, saturating increment, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: issues one req/ack access per EX/MEM load or store,
// stalls the front of the pipeline until the access completes, and resolves
// the branch decision into pc_src/flush.
// Optional build macro MEM_TIMEOUT_EN: aborts an access that waits TIMEOUT
// REQ cycles without an ack and raises the sticky mem_err flag.
module mem_stage_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              branch,
  input  logic              zero,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [DATA_W-1:0] rdata2out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              pc_src,
  output logic              flush,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  mem_state_t        state_q, state_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              mem_err_q, mem_err_d;
  logic              access_s;
  logic              stall_s;
  logic              timeout_s;

  assign access_s = memread | memwrite;
  // Stall while an access is being launched and for every cycle it is in flight;
  // DONE releases the pipeline so the instruction leaves EX/MEM exactly once.
  assign stall_s  = ((state_q == IDLE) && access_s) || (state_q == REQ);

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_s;
  logic            to_clr_s;
  logic            to_inc_s;

  assign to_clr_s  = (state_q == IDLE) && access_s;
  assign to_inc_s  = (state_q == REQ);

  sat_counter #(.W(TO_W)) u_timeout_cnt (
    .clk   (clock),
    .rst_n (reset),
    .clr_i (to_clr_s),
    .inc_i (to_inc_s),
    .cnt_o (to_cnt_s)
  );

  // The count reaches TIMEOUT on the edge that closes the TIMEOUT-th REQ cycle.
  assign timeout_s = (state_q == REQ) && (to_cnt_s == TO_W'(TIMEOUT - 1));
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT);
  assign timeout_s        = 1'b0;
`endif

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clock),
    .rst_n (reset),
    .clr_i (1'b0),
    .inc_i (stall_s),
    .cnt_o (stall_cnt)
  );

  // Next-state and next-output decode for the access sequencer.
  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    mem_err_d    = mem_err_q;
    case (state_q)
      IDLE: begin
        if (access_s) begin
          state_d      = REQ;
          dmem_req_d   = 1'b1;
          dmem_we_d    = memwrite ? MEM_OP_WRITE : MEM_OP_READ;
          dmem_addr_d  = alu_result[ADDR_W-1:0];
          dmem_wdata_d = rdata2out;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dmem_ack) begin
          state_d    = DONE;
          dmem_req_d = 1'b0;
          if (dmem_we_q == MEM_OP_READ) begin
            load_data_d  = dmem_rdata;
            load_valid_d = 1'b1;
          end else begin
            load_valid_d = 1'b0;
          end
        end else if (timeout_s) begin
          state_d    = DONE;
          dmem_req_d = 1'b0;
          mem_err_d  = 1'b1;
          if (dmem_we_q == MEM_OP_READ) begin
            load_data_d  = '0;
            load_valid_d = 1'b1;
          end else begin
            load_valid_d = 1'b0;
          end
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered memory-interface outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign mem_err    = mem_err_q;
  assign stall      = stall_s;
  assign pc_src     = branch & zero;
  assign flush      = (branch & zero) & ~stall_s;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: scenario tasks drive accesses and
// a negedge monitor pops expected requests/loads from scoreboard queues.
module tb_mem_stage_ctrl;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              branch = 1'b0;
  logic              zero = 1'b0;
  logic              memread = 1'b0;
  logic              memwrite = 1'b0;
  logic [31:0]       alu_result = 32'h0;
  logic [DATA_W-1:0] rdata2out = 32'h0;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack = 1'b0;
  logic [DATA_W-1:0] dmem_rdata = 32'h0;
  logic              stall;
  logic              pc_src;
  logic              flush;
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              mem_err;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clock = ~clock;

  mem_stage_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .branch(branch), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alu_result(alu_result),
    .rdata2out(rdata2out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .pc_src(pc_src), .flush(flush),
    .load_data(load_data), .load_valid(load_valid), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] load_q[$];
  req_t        cur_req;
  logic [31:0] exp_ld;
  logic        prev_req = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_load_data = 32'h0;
  int          exp_stall_cnt = 0;
  int          st_c, rq_c, lv_c;

  // Scoreboard monitor: check each new request, its stability, and each load pulse.
  always @(negedge clock) begin
    if (dmem_req && !prev_req) begin
      n_checks++;
      if (req_q.size() == 0) begin
        n_fail++;
        $display("FAIL req_unexpected: got request to %h, expected none", dmem_addr);
      end else begin
        cur_req = req_q.pop_front();
        if (dmem_we !== cur_req.we || dmem_addr !== cur_req.addr ||
            (cur_req.we && dmem_wdata !== cur_req.wdata)) begin
          n_fail++;
          $display("FAIL req_fields: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                   dmem_we, dmem_addr, dmem_wdata, cur_req.we, cur_req.addr, cur_req.wdata);
        end
      end
    end else if (dmem_req) begin
      n_checks++;
      if (dmem_we !== cur_req.we || dmem_addr !== cur_req.addr ||
          (cur_req.we && dmem_wdata !== cur_req.wdata)) begin
        n_fail++;
        $display("FAIL req_stable: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                 dmem_we, dmem_addr, dmem_wdata, cur_req.we, cur_req.addr, cur_req.wdata);
      end
    end
    if (load_valid) begin
      n_checks++;
      if (load_q.size() == 0) begin
        n_fail++;
        $display("FAIL load_unexpected: got load_valid with data %h, expected no pulse", load_data);
      end else begin
        exp_ld = load_q.pop_front();
        if (load_data !== exp_ld) begin
          n_fail++;
          $display("FAIL load_data: got %h expected %h", load_data, exp_ld);
        end
      end
    end
    prev_req = dmem_req;
  end

  // Drive one access; ack arrives in REQ cycle n (or never). Only counts cycles.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdv, input int n,
                            input bit give_ack, output int s_c, output int r_c, output int l_c);
    s_c = 0; r_c = 0; l_c = 0;
    memread = rd; memwrite = wr; alu_result = addr; rdata2out = wd;
    for (int c = 0; c < n + 3; c++) begin
      if (give_ack && c == n) begin
        dmem_ack = 1'b1; dmem_rdata = rdv;
      end
      if (c == n + 2) begin
        memread = 1'b0; memwrite = 1'b0;
      end
      @(negedge clock);
      if (stall) s_c++;
      if (dmem_req) r_c++;
      if (load_valid) l_c++;
      @(posedge clock); #1;
      dmem_ack = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock); #1;
    n_checks++;
    if ({dmem_req, dmem_we, load_valid, mem_err, stall} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got req/we/lv/err/stall=%b expected 00000",
               {dmem_req, dmem_we, load_valid, mem_err, stall});
    end
    n_checks++;
    if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || load_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h wdata=%h load=%h expected all 0", dmem_addr, dmem_wdata, load_data);
    end
    n_checks++;
    if (stall_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_load();
    req_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    load_q.push_back(32'hDEAD_BEEF);
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, st_c, rq_c, lv_c);
    exp_stall_cnt += 2; exp_load_data = 32'hDEAD_BEEF;
    n_checks++;
    if (st_c !== 2 || rq_c !== 1 || lv_c !== 1) begin
      n_fail++;
      $display("FAIL load_cycles: got stall=%0d req=%0d lv=%0d expected 2 1 1", st_c, rq_c, lv_c);
    end
    n_checks++;
    if (stall_cnt !== 16'(exp_stall_cnt) || load_data !== exp_load_data) begin
      n_fail++;
      $display("FAIL load_state: got stall_cnt=%0d load=%h expected %0d %h",
               stall_cnt, load_data, exp_stall_cnt, exp_load_data);
    end
  endtask

  task automatic test_store();
    req_q.push_back('{we: 1'b1, addr: 32'h204, wdata: 32'h1234_5678});
    run_access(1'b0, 1'b1, 32'h204, 32'h1234_5678, 32'hFFFF_0000, 5, 1'b1, st_c, rq_c, lv_c);
    exp_stall_cnt += 6;
    n_checks++;
    if (st_c !== 6 || rq_c !== 5 || lv_c !== 0) begin
      n_fail++;
      $display("FAIL store_cycles: got stall=%0d req=%0d lv=%0d expected 6 5 0", st_c, rq_c, lv_c);
    end
    n_checks++;
    if (stall_cnt !== 16'(exp_stall_cnt) || load_data !== exp_load_data) begin
      n_fail++;
      $display("FAIL store_state: got stall_cnt=%0d load=%h expected %0d %h",
               stall_cnt, load_data, exp_stall_cnt, exp_load_data);
    end
  endtask

  task automatic test_back_to_back();
    // Read and write together behave as a write; a load follows immediately.
    req_q.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'hA5A5_5A5A});
    run_access(1'b1, 1'b1, 32'h40, 32'hA5A5_5A5A, 32'h7777_7777, 2, 1'b1, st_c, rq_c, lv_c);
    exp_stall_cnt += 3;
    n_checks++;
    if (st_c !== 3 || rq_c !== 2 || lv_c !== 0) begin
      n_fail++;
      $display("FAIL rw_cycles: got stall=%0d req=%0d lv=%0d expected 3 2 0", st_c, rq_c, lv_c);
    end
    req_q.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0});
    load_q.push_back(32'h0F0F_1234);
    run_access(1'b1, 1'b0, 32'h44, 32'h0, 32'h0F0F_1234, 3, 1'b1, st_c, rq_c, lv_c);
    exp_stall_cnt += 4; exp_load_data = 32'h0F0F_1234;
    n_checks++;
    if (st_c !== 4 || rq_c !== 3 || lv_c !== 1) begin
      n_fail++;
      $display("FAIL b2b_cycles: got stall=%0d req=%0d lv=%0d expected 4 3 1", st_c, rq_c, lv_c);
    end
    n_checks++;
    if (stall_cnt !== 16'(exp_stall_cnt) || load_data !== exp_load_data) begin
      n_fail++;
      $display("FAIL b2b_state: got stall_cnt=%0d load=%h expected %0d %h",
               stall_cnt, load_data, exp_stall_cnt, exp_load_data);
    end
  endtask

  task automatic test_branch();
    branch = 1'b1; zero = 1'b1; #1;
    n_checks++;
    if ({pc_src, flush} !== 2'b11) begin
      n_fail++;
      $display("FAIL branch_taken: got pc_src/flush=%b expected 11", {pc_src, flush});
    end
    zero = 1'b0; #1;
    n_checks++;
    if ({pc_src, flush} !== 2'b00) begin
      n_fail++;
      $display("FAIL branch_not_taken: got pc_src/flush=%b expected 00", {pc_src, flush});
    end
    zero = 1'b1; memread = 1'b1; #1;
    n_checks++;
    if ({pc_src, flush, stall} !== 3'b101) begin
      n_fail++;
      $display("FAIL branch_stalled: got pc_src/flush/stall=%b expected 101", {pc_src, flush, stall});
    end
    memread = 1'b0; branch = 1'b0; zero = 1'b0; #1;
  endtask

  task automatic test_spurious_ack();
    for (int c = 0; c < 2; c++) begin
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      @(negedge clock);
      n_checks++;
      if ({stall, load_valid, dmem_req} !== 3'b000) begin
        n_fail++;
        $display("FAIL spurious_ack: got stall/lv/req=%b expected 000", {stall, load_valid, dmem_req});
      end
      @(posedge clock); #1;
    end
    dmem_ack = 1'b0;
    @(negedge clock);
    n_checks++;
    if (load_valid !== 1'b0 || load_data !== exp_load_data || stall_cnt !== 16'(exp_stall_cnt)) begin
      n_fail++;
      $display("FAIL spurious_state: got lv=%b load=%h stall_cnt=%0d expected 0 %h %0d",
               load_valid, load_data, stall_cnt, exp_load_data, exp_stall_cnt);
    end
    @(posedge clock); #1;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    req_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
    load_q.push_back(32'h0);
    run_access(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, TIMEOUT, 1'b0, st_c, rq_c, lv_c);
    exp_stall_cnt += TIMEOUT + 1; exp_load_data = 32'h0;
    n_checks++;
    if (st_c !== TIMEOUT + 1 || rq_c !== TIMEOUT || lv_c !== 1) begin
      n_fail++;
      $display("FAIL timeout_cycles: got stall=%0d req=%0d lv=%0d expected %0d %0d 1",
               st_c, rq_c, lv_c, TIMEOUT + 1, TIMEOUT);
    end
    n_checks++;
    if (mem_err !== 1'b1 || load_data !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_state: got err=%b load=%h expected 1 0", mem_err, load_data);
    end
    req_q.push_back('{we: 1'b0, addr: 32'h304, wdata: 32'h0});
    load_q.push_back(32'h0000_0011);
    run_access(1'b1, 1'b0, 32'h304, 32'h0, 32'h0000_0011, 1, 1'b1, st_c, rq_c, lv_c);
    exp_stall_cnt += 2; exp_load_data = 32'h0000_0011;
    n_checks++;
    if (mem_err !== 1'b1 || stall_cnt !== 16'(exp_stall_cnt)) begin
      n_fail++;
      $display("FAIL timeout_sticky: got err=%b stall_cnt=%0d expected 1 %0d", mem_err, stall_cnt, exp_stall_cnt);
    end
  endtask
`endif

  task automatic test_reset_mid_req();
    req_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h0});
    memread = 1'b1; alu_result = 32'h500;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0; memread = 1'b0; #1;
    exp_stall_cnt = 0; exp_load_data = 32'h0;
    n_checks++;
    if ({dmem_req, dmem_we, load_valid, mem_err, stall, pc_src, flush} !== 7'b0) begin
      n_fail++;
      $display("FAIL rst_mid_flags: got req/we/lv/err/stall/pc/flush=%b expected 0000000",
               {dmem_req, dmem_we, load_valid, mem_err, stall, pc_src, flush});
    end
    n_checks++;
    if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || load_data !== 32'h0 || stall_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid_data: got addr=%h wdata=%h load=%h stall_cnt=%0d expected all 0",
               dmem_addr, dmem_wdata, load_data, stall_cnt);
    end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clock);
    n_checks++;
    if ({load_valid, stall, dmem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL late_ack: got lv/stall/req=%b expected 000", {load_valid, stall, dmem_req});
    end
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    n_checks++;
    if (load_valid !== 1'b0 || load_data !== 32'h0 || stall_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL late_ack_state: got lv=%b load=%h stall_cnt=%0d expected 0 0 0",
               load_valid, load_data, stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_branch();
    test_spurious_ack();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_req();
    repeat (2) @(posedge clock); #1;
    n_checks++;
    if (req_q.size() !== 0 || load_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d requests and %0d loads pending, expected 0 0",
               req_q.size(), load_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
